// File: rtl/home_inventory_event_detector.sv
// Per-channel weight-change event detector: tare correction, baseline delta,
// threshold decision and event bookkeeping in a three-stage pipeline.
module home_inventory_event_detector #(
  parameter int NUM_CH = 8,
  parameter int TS_W   = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   enable,
  input  logic                   ts_tick,
  input  logic                   clear_counts,
  input  logic [31:0]            threshold,
  input  logic [32*NUM_CH-1:0]   tare_flat,
  input  logic                   sample_valid,
  input  logic [2:0]             sample_ch,
  input  logic [31:0]            sample_raw,
  output logic [32*NUM_CH-1:0]   evt_count_flat,
  output logic [32*NUM_CH-1:0]   evt_last_delta_flat,
  output logic [TS_W-1:0]        evt_last_ts,
  output logic                   evt_pulse,
  output logic [2:0]             evt_ch
);

  localparam int DATA_W = 32;

  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1])
      sat32 = v[DATA_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      sat32 = v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W:0] abs33(input logic signed [DATA_W:0] v);
    abs33 = v[DATA_W] ? 33'(-v) : v;
  endfunction

  logic [TS_W-1:0]            ts_q;
  logic [NUM_CH-1:0]          primed_q;
  logic signed [DATA_W-1:0]   baseline_q   [NUM_CH];
  logic [DATA_W-1:0]          count_q      [NUM_CH];
  logic signed [DATA_W-1:0]   last_delta_q [NUM_CH];
  logic signed [DATA_W-1:0]   tare_a       [NUM_CH];

  logic                       vld_p0, vld_p1;
  logic [2:0]                 ch_p0, ch_p1;
  logic signed [DATA_W-1:0]   raw_p0;
  logic [TS_W-1:0]            ts_p0, ts_p1;
  logic signed [DATA_W-1:0]   net_p1;
  logic signed [DATA_W:0]     delta_p1;

  logic                       commit, is_evt, base_wr;
  logic signed [DATA_W-1:0]   base_fwd, net_d;
  logic signed [DATA_W:0]     raw_x, tare_x, net_x, delta_d;

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      tare_a[n]                          = tare_flat[32*n +: 32];
      evt_count_flat[32*n +: 32]         = count_q[n];
      evt_last_delta_flat[32*n +: 32]    = last_delta_q[n];
    end
  end

  // Stage 2 decision; a disabled detector commits nothing still in flight.
  always_comb begin
    commit  = vld_p1 && enable;
    is_evt  = commit && primed_q[ch_p1] && (threshold != 32'd0) &&
              (abs33(delta_p1) >= {1'b0, threshold});
    base_wr = commit && (!primed_q[ch_p1] || (threshold == 32'd0) || is_evt);
  end

  // Stage 1 compute, using the baseline stage 2 is writing this cycle if it matches.
  always_comb begin
    base_fwd = (base_wr && (ch_p1 == ch_p0)) ? net_p1 : baseline_q[ch_p0];
    raw_x    = {raw_p0[DATA_W-1], raw_p0};
    tare_x   = {tare_a[ch_p0][DATA_W-1], tare_a[ch_p0]};
    net_x    = raw_x - tare_x;
    net_d    = sat32(net_x);
    delta_d  = {net_d[DATA_W-1], net_d} - {base_fwd[DATA_W-1], base_fwd};
  end

  // Stage 0 -> stage 1 data registers
  always_ff @(posedge wb_clk_i) begin
    ch_p0    <= sample_ch;
    raw_p0   <= sample_raw;
    ts_p0    <= ts_q;
    ch_p1    <= ch_p0;
    net_p1   <= net_d;
    delta_p1 <= delta_d;
    ts_p1    <= ts_p0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ts_q        <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      primed_q    <= '0;
      evt_pulse   <= 1'b0;
      evt_ch      <= 3'd0;
      evt_last_ts <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        baseline_q[n]   <= '0;
        count_q[n]      <= '0;
        last_delta_q[n] <= '0;
      end
    end else begin
      if (enable && ts_tick)
        ts_q <= ts_q + 1'b1;
      vld_p0    <= sample_valid && enable;
      vld_p1    <= vld_p0 && enable;
      evt_pulse <= is_evt;

      if (!enable)
        primed_q <= '0;
      else if (commit)
        primed_q[ch_p1] <= 1'b1;

      if (base_wr)
        baseline_q[ch_p1] <= net_p1;

      if (clear_counts)
        for (int n = 0; n < NUM_CH; n++)
          count_q[n] <= '0;

      // Event bookkeeping; overrides the clear for the event channel.
      if (is_evt) begin
        if (clear_counts)
          count_q[ch_p1] <= 32'd1;
        else if (count_q[ch_p1] != 32'hFFFF_FFFF)
          count_q[ch_p1] <= count_q[ch_p1] + 32'd1;
        last_delta_q[ch_p1] <= sat32(delta_p1);
        evt_last_ts         <= ts_p1;
        evt_ch              <= ch_p1;
      end
    end
  end

endmodule

// File: tb/tb_home_inventory_event_detector.sv
// Scoreboard bench for home_inventory_event_detector using directed vectors.
module tb_home_inventory_event_detector;

  localparam int NUM_CH = 8;
  localparam int TS_W   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable, ts_tick, clear_counts, sample_valid;
  logic [31:0]          threshold, sample_raw;
  logic [32*NUM_CH-1:0] tare_flat;
  logic [2:0]           sample_ch;
  logic [32*NUM_CH-1:0] evt_count_flat, evt_last_delta_flat;
  logic [TS_W-1:0]      evt_last_ts;
  logic                 evt_pulse;
  logic [2:0]           evt_ch;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          ch;
    logic [31:0] cnt;
    logic [31:0] dlt;
    logic [31:0] ts;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  home_inventory_event_detector #(.NUM_CH(NUM_CH), .TS_W(TS_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .ts_tick(ts_tick),
    .clear_counts(clear_counts), .threshold(threshold), .tare_flat(tare_flat),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_raw(sample_raw),
    .evt_count_flat(evt_count_flat), .evt_last_delta_flat(evt_last_delta_flat),
    .evt_last_ts(evt_last_ts), .evt_pulse(evt_pulse), .evt_ch(evt_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [31:0] raw, input bit ev,
                      input logic [31:0] cnt, input logic [31:0] dlt, input logic [31:0] ts);
    exp_t e;
    sample_valid = 1'b1;
    sample_ch    = 3'(ch);
    sample_raw   = raw;
    if (ev) begin
      e.ch = ch; e.cnt = cnt; e.dlt = dlt; e.ts = ts; e.at = cyc + 3;
      exp_q.push_back(e);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (evt_pulse) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt_pulse", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_ch",         evt_ch, e.ch);
        chk("evt_count",      evt_count_flat[32*e.ch +: 32], e.cnt);
        chk("evt_last_delta", evt_last_delta_flat[32*e.ch +: 32], e.dlt);
        chk("evt_last_ts",    evt_last_ts, e.ts);
        chk("evt_latency",    cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; ts_tick = 1'b0; clear_counts = 1'b0;
    sample_valid = 1'b0; sample_ch = 3'd0; sample_raw = '0;
    threshold = '0; tare_flat = '0;
    tick(); tick();
    chk("rst_evt_pulse", evt_pulse, 0);
    chk("rst_evt_ch", evt_ch, 0);
    chk("rst_evt_last_ts", evt_last_ts, 0);
    chk("rst_counts_zero", evt_count_flat == '0, 1);
    chk("rst_deltas_zero", evt_last_delta_flat == '0, 1);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // Priming, threshold and negative delta on ch0
    tare_flat[31:0] = 32'd100;
    threshold = 32'd50;
    send(0, 32'd1100, 0, 0, 0, 0);
    tick(); tick();
    send(0, 32'd1160, 1, 32'd1, 32'd60, 0);
    tick(); tick();
    send(0, 32'd1180, 0, 0, 0, 0);
    tick(); tick();
    send(0, 32'd1000, 1, 32'd2, 32'hFFFF_FF60, 0);
    repeat (4) tick();

    // Back-to-back forwarding on ch3
    threshold = 32'd100;
    send(3, 32'd0,   0, 0, 0, 0);
    send(3, 32'd200, 1, 32'd1, 32'd200, 0);
    send(3, 32'd210, 0, 0, 0, 0);
    repeat (4) tick();

    // Delta saturation on ch1
    threshold = 32'd1;
    send(1, 32'h8000_0000, 0, 0, 0, 0);
    tick();
    send(1, 32'h7FFF_FFFF, 1, 32'd1, 32'h7FFF_FFFF, 0);
    repeat (4) tick();

    // Build count2 up to 5, then clear coincident with the sixth event
    send(2, 32'd0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      send(2, 32'(10 * i), 1, 32'(i), 32'd10, 0);
    repeat (4) tick();
    send(2, 32'd60, 1, 32'd1, 32'd10, 0);
    tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    for (int n = 0; n < NUM_CH; n++)
      if (n != 2) chk($sformatf("clear_count_ch%0d", n), evt_count_flat[32*n +: 32], 0);
    repeat (3) tick();

    // Timestamp capture on ch4
    send(4, 32'd0, 0, 0, 0, 0);
    ts_tick = 1'b1;
    repeat (7) tick();
    ts_tick = 1'b0;
    send(4, 32'd100, 1, 32'd1, 32'd100, 32'd7);
    repeat (4) tick();

    // Enable drop flushes an in-flight event, re-enable re-primes
    send(4, 32'd500, 0, 0, 0, 0);
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    tick();
    send(4, 32'd600, 0, 0, 0, 0);
    tick(); tick();
    send(4, 32'd700, 1, 32'd2, 32'd100, 32'd7);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_counts", evt_count_flat == '0, 1);
    chk("async_rst_ts", evt_last_ts, 0);
    chk("async_rst_evt_ch", evt_ch, 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/home_inventory_event_detector.md
# home_inventory_event_detector

Per-channel weight-change event detector sitting directly downstream of the ADC/calibration register file. It consumes tare-corrected ADC samples one channel at a time and compares each against a per-channel baseline. When the change meets a programmable threshold it updates that channel's event count and last delta, records a shared timestamp, and pulses an event strobe. Its outputs drive the read-only EVT_COUNT_CHn, EVT_LAST_DELTA_CHn and EVT_LAST_TS registers and the event interrupt source.

## Interface
- NUM_CH, 8, number of channels; channel index width is 3.
- TS_W, 32, timestamp counter width.
- wb_clk_i  in  1  clock; all state updates on the rising edge.
- wb_rst_i  in  1  reset, asynchronous and active-high.
- enable  in  1  detector enable, driven by CTRL.ENABLE.
- ts_tick  in  1  single-cycle timebase strobe; advances the timestamp.
- clear_counts  in  1  single-cycle pulse; zeroes all event counts.
- threshold  in  32  unsigned event threshold; 0 disables detection.
- tare_flat  in  32*NUM_CH  signed tare per channel; channel n occupies bits [32n+31:32n].
- sample_valid  in  1  a sample is presented this cycle; there is no backpressure.
- sample_ch  in  3  channel index of the sample.
- sample_raw  in  32  signed raw ADC value.
- evt_count_flat  out  32*NUM_CH  per-channel event counts.
- evt_last_delta_flat  out  32*NUM_CH  per-channel signed delta of the last event.
- evt_last_ts  out  TS_W  timestamp of the most recent event on any channel.
- evt_pulse  out  1  one-cycle strobe per detected event.
- evt_ch  out  3  channel of the most recent event; held until the next event.

## Operation
- Timestamp counter
  - ts increments by 1 on each cycle with ts_tick=1 and enable=1.
  - Wraps from all-ones to 0.
  - Holds while enable=0.
- Stage 0 (accept): when sample_valid=1 and enable=1, register ch, raw and the current ts (the pre-increment value if ts_tick fires in the same cycle).
  - Samples with enable=0 are dropped.
- Stage 1 (compute)
  - net = raw − tare[ch], computed at 33 bits and saturated to signed 32.
  - delta = net − baseline[ch], computed at 33 bits with no saturation.
  - Both are registered.
- Baseline forwarding: if stage 2 is writing baseline[ch] for the same channel in the same cycle, stage 1 uses the value being written. Back-to-back samples on one channel therefore behave exactly as if they were spaced apart.
- Stage 2 (decide), per channel ch:
  - primed[ch]=0: baseline ← net, primed ← 1, no event.
  - threshold=0: baseline ← net, no event.
  - |delta| ≥ threshold (unsigned 33-bit compare):
    - event; baseline ← net.
    - count[ch] ← count[ch]+1, saturating at 0xFFFF_FFFF.
    - last_delta[ch] ← delta saturated to signed 32.
    - evt_last_ts ← captured ts; evt_ch ← ch; evt_pulse ← 1.
  - Otherwise: no change; baseline is kept, so slow drift accumulates until it crosses the threshold.
- clear_counts
  - Zeroes all counts.
  - If it coincides with a stage-2 event, that channel's count becomes 1; last_delta and ts still update.
- enable falling edge
  - Clears all primed bits and flushes both pipeline stages; no event is emitted for in-flight samples.
  - Counts, deltas and the timestamp are retained.

## Timing
- Reset values:
  - counts 0, last_delta 0, evt_last_ts 0, evt_ch 0, evt_pulse 0.
  - ts 0, baselines 0, primed all 0.
  - Pipeline valid bits 0.
- Throughput: one sample per cycle, any channel order.
- Latency: a sample accepted at edge N updates outputs at edge N+2; evt_pulse is high for exactly the cycle following edge N+2.
- Reset asserted mid-operation clears everything immediately (asynchronously); in-flight samples are lost.

## Test plan
- Priming and threshold, with tare0=100, threshold=50; ch0 raw 1100, then 1160, then 1180:
  - 1100 primes, no event.
  - 1160 → count0=1, last_delta0=60.
  - 1180 (delta 20) → no event.
- Negative delta: continuing the previous case, ch0 raw 1000 → count0=2, last_delta0=0xFFFF_FF60, evt_ch=0, evt_pulse high one cycle at N+2.
- Forwarding, with tare3=0, threshold=100; ch3 raw 0, 200, 210 on consecutive cycles → exactly one event, count3=1, last_delta3=200.
- Saturation, with threshold=1; ch1 raw 0x8000_0000, then raw 0x7FFF_FFFF → count1=1, last_delta1=0x7FFF_FFFF.
- clear_counts coincident with a ch2 event while count2=5 → count2=1 and all other counts 0 on the same edge.
- Timestamp and enable:
  - Apply 7 ts_ticks, then a ch4 event → evt_last_ts=7.
  - Drop enable during the pipeline → no evt_pulse.
  - Re-enable; the next ch4 sample primes with no event.
